// File: rtl/ring_period_counter.sv
// ring_period_counter: counts rising edges of an asynchronous ring-oscillator
// output over a programmable window of wb_clk_i cycles. A batch repeats the
// measurement repeat_n times and keeps last/min/max/sum for readback.
//
// Handshake: start is a single-cycle request with no ready; it is accepted only
// when the block is idle (busy=0), active=1 and gate_cycles!=0, and is silently
// dropped otherwise. busy rises the cycle after acceptance and falls when the
// FSM returns to IDLE; done or aborted pulses for one cycle to mark the end.
module ring_period_counter #(
    parameter int COUNT_W     = 16,
    parameter int GATE_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 active,
    input  logic                 ring_in,
    input  logic                 start,
    input  logic [GATE_W-1:0]    gate_cycles,
    input  logic [7:0]           repeat_n,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [COUNT_W-1:0]   last_count,
    output logic [COUNT_W-1:0]   min_count,
    output logic [COUNT_W-1:0]   max_count,
    output logic [COUNT_W+7:0]   sum_count,
    output logic [7:0]           runs_done,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        COUNT = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 prev_q;
    logic                 ring_sync;
    logic                 ring_edge;
    logic [GATE_W-1:0]    gate_lat;
    logic [GATE_W-1:0]    gate_cnt;
    logic [7:0]           rep_lat;
    logic [COUNT_W-1:0]   cnt;
    logic [7:0]           runs_next;

    assign ring_sync = sync_q[SYNC_STAGES-1];
    assign ring_edge = ring_sync & ~prev_q;
    assign runs_next = runs_done + 8'd1;
    assign state_dbg = state;

    // Synchroniser chain plus previous-value flop for rising-edge detection.
    // prev always follows sync, so at ARM it already holds the current level
    // and the first COUNT cycle cannot see a spurious edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ring_in};
            prev_q <= ring_sync;
        end
    end

    // Measurement FSM with registered status/result outputs; a drop of active
    // outside IDLE overrides every state action, including the STORE update.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            last_count <= '0;
            min_count  <= '1;
            max_count  <= '0;
            sum_count  <= '0;
            runs_done  <= '0;
            gate_lat   <= '0;
            gate_cnt   <= '0;
            rep_lat    <= '0;
            cnt        <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (state != IDLE && !active) begin
                state   <= IDLE;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && active && gate_cycles != '0) begin
                            gate_lat  <= gate_cycles;
                            rep_lat   <= (repeat_n == 8'd0) ? 8'd1 : repeat_n;
                            min_count <= '1;
                            max_count <= '0;
                            sum_count <= '0;
                            runs_done <= '0;
                            busy      <= 1'b1;
                            state     <= ARM;
                        end
                    end
                    ARM: begin
                        cnt      <= '0;
                        gate_cnt <= gate_lat;
                        state    <= COUNT;
                    end
                    COUNT: begin
                        if (ring_edge && cnt != {COUNT_W{1'b1}}) begin
                            cnt <= cnt + COUNT_W'(1);
                        end
                        gate_cnt <= gate_cnt - GATE_W'(1);
                        if (gate_cnt == GATE_W'(1)) begin
                            state <= STORE;
                        end
                    end
                    STORE: begin
                        last_count <= cnt;
                        if (cnt < min_count) begin
                            min_count <= cnt;
                        end
                        if (cnt > max_count) begin
                            max_count <= cnt;
                        end
                        sum_count <= sum_count + {8'd0, cnt};
                        runs_done <= runs_next;
                        if (runs_next < rep_lat) begin
                            state <= ARM;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_period_counter.sv
// Directed testbench for ring_period_counter: a 16-bit instance for the main
// scenarios and a 4-bit instance for counter saturation.
`timescale 1ns/1ps
module tb_ring_period_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        active = 1'b0;
    logic        ring_in = 1'b0;
    logic        ring2 = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [23:0] gate_cycles = '0;
    logic [7:0]  repeat_n = '0;
    logic        ring_on = 1'b0;
    int          ring_half_ns = 50;

    logic        busy, done, aborted;
    logic [15:0] last_count, min_count, max_count;
    logic [23:0] sum_count;
    logic [7:0]  runs_done;
    logic [2:0]  state_dbg;

    logic        busy2, done2, aborted2;
    logic [3:0]  last2, min2, max2;
    logic [11:0] sum2;
    logic [7:0]  runs2;
    logic [2:0]  state2;

    int n_cmp = 0;
    int n_err = 0;

    ring_period_counter #(.COUNT_W(16), .GATE_W(24), .SYNC_STAGES(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .ring_in(ring_in),
        .start(start), .gate_cycles(gate_cycles), .repeat_n(repeat_n),
        .busy(busy), .done(done), .aborted(aborted), .last_count(last_count),
        .min_count(min_count), .max_count(max_count), .sum_count(sum_count),
        .runs_done(runs_done), .state_dbg(state_dbg)
    );

    ring_period_counter #(.COUNT_W(4), .GATE_W(24), .SYNC_STAGES(2)) dut_sat (
        .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .ring_in(ring2),
        .start(start2), .gate_cycles(gate_cycles), .repeat_n(repeat_n),
        .busy(busy2), .done(done2), .aborted(aborted2), .last_count(last2),
        .min_count(min2), .max_count(max2), .sum_count(sum2),
        .runs_done(runs2), .state_dbg(state2)
    );

    // Clock and reset block: 10 ns clock, reset driven from the main sequence.
    always #5 clk = ~clk;

    // Ring oscillator models: period 2*ring_half_ns (10 clocks by default),
    // and a fixed 4-clock ring for the saturating instance.
    always begin
        #(ring_half_ns);
        if (ring_on) ring_in = ~ring_in;
        else         ring_in = 1'b0;
    end
    always #20 ring2 = ~ring2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on one instance, then count negedges until done.
    // lat=1 is the first cycle after acceptance (ARM); -1 means timeout.
    task automatic run_batch(input bit sel, input int budget, output int lat);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            lat++;
            if ((sel ? done2 : done) === 1'b1) break;
            if (lat > budget) begin
                lat = -1;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  seen;

        // 1. reset values
        rst = 1'b1;
        active = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_last", last_count, 0);
        check("rst_min", min_count, 16'hFFFF);
        check("rst_max", max_count, 0);
        check("rst_sum", sum_count, 0);
        check("rst_runs", runs_done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 2. single run, ring period 10, window 100
        ring_on = 1'b1;
        repeat (5) @(negedge clk);
        gate_cycles = 24'd100;
        repeat_n = 8'd1;
        run_batch(0, 1000, lat);
        check("t2_latency", lat, 103);
        check("t2_last", last_count, 10);
        check("t2_min", min_count, 10);
        check("t2_max", max_count, 10);
        check("t2_sum", sum_count, 10);
        check("t2_runs", runs_done, 1);
        check("t2_busy_at_done", busy, 1);
        @(negedge clk);
        check("t2_busy_after", busy, 0);
        check("t2_done_one_cycle", done, 0);

        // 3. three runs of window 60
        gate_cycles = 24'd60;
        repeat_n = 8'd3;
        run_batch(0, 1000, lat);
        check("t3_latency", lat, 187);
        check("t3_last", last_count, 6);
        check("t3_min", min_count, 6);
        check("t3_max", max_count, 6);
        check("t3_sum", sum_count, 18);
        check("t3_runs", runs_done, 3);
        @(negedge clk);

        // 3b. ring held low
        ring_on = 1'b0;
        repeat (10) @(negedge clk);
        run_batch(0, 1000, lat);
        check("t3b_latency", lat, 187);
        check("t3b_last", last_count, 0);
        check("t3b_min", min_count, 0);
        check("t3b_max", max_count, 0);
        check("t3b_sum", sum_count, 0);
        check("t3b_runs", runs_done, 3);
        @(negedge clk);

        // 4. saturation on the 4-bit instance: 50 edges in 200 cycles
        gate_cycles = 24'd200;
        repeat_n = 8'd0;
        run_batch(1, 1000, lat);
        check("t4_latency", lat, 203);
        check("t4_last", last2, 15);
        check("t4_min", min2, 15);
        check("t4_max", max2, 15);
        check("t4_sum", sum2, 15);
        check("t4_runs", runs2, 1);
        @(negedge clk);

        // 5a. gate_cycles=0 is ignored
        gate_cycles = 24'd0;
        repeat_n = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy || done) seen = 1'b1;
            @(negedge clk);
        end
        check("t5_gate0_ignored", seen, 0);

        // 5b. start with active low is ignored
        active = 1'b0;
        gate_cycles = 24'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_inactive_busy", busy, 0);
        check("t5_inactive_aborted", aborted, 0);
        active = 1'b1;
        @(negedge clk);

        // 5c. second start during COUNT changes nothing
        ring_on = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            lat++;
            start = (lat == 20);
            if (lat == 20) gate_cycles = 24'd7;
            if (done === 1'b1) break;
            if (lat > 1000) begin
                lat = -1;
                break;
            end
        end
        start = 1'b0;
        check("t5_restart_latency", lat, 103);
        check("t5_restart_last", last_count, 10);
        @(negedge clk);

        // 6. abort during COUNT of run 2
        gate_cycles = 24'd60;
        repeat_n = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 2; k <= 90; k++) begin
            @(negedge clk);
            if (done || aborted) seen = 1'b1;
        end
        check("t6_no_early_end", seen, 0);
        active = 1'b0;
        @(negedge clk);
        check("t6_aborted", aborted, 1);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_runs", runs_done, 1);
        check("t6_last", last_count, 6);
        check("t6_min", min_count, 6);
        check("t6_max", max_count, 6);
        check("t6_sum", sum_count, 6);
        @(negedge clk);
        check("t6_aborted_one_cycle", aborted, 0);
        active = 1'b1;
        @(negedge clk);

        // 6b. async reset during COUNT
        gate_cycles = 24'd100;
        repeat_n = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("t6b_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6b_busy", busy, 0);
        check("t6b_last", last_count, 0);
        check("t6b_min", min_count, 16'hFFFF);
        check("t6b_runs", runs_done, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done || aborted || busy) seen = 1'b1;
        end
        check("t6b_no_pulse", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
